// File: rtl/fifo_relay_if.sv
// fifo_relay_if: req/ack handshake bundle for both sides of fifo_relay.
// master: the relay's view (read-master on rm_*, write-master on wm_*).
// slave : the surrounding FIFOs' view (upstream read port, downstream write port).
interface fifo_relay_if #(
    parameter int unsigned dw = 8
);
    logic [dw-1:0] rm_data;
    logic          rm_req;
    logic          rm_ack;
    logic [dw-1:0] wm_data;
    logic          wm_req;
    logic          wm_ack;

    modport master (
        input  rm_data,
        input  rm_req,
        output rm_ack,
        output wm_data,
        output wm_req,
        input  wm_ack
    );

    modport slave (
        output rm_data,
        output rm_req,
        input  rm_ack,
        input  wm_data,
        input  wm_req,
        output wm_ack
    );
endinterface

// File: rtl/fifo_relay.sv
// fifo_relay: accepts words from an upstream FIFO read port (four-phase
// req/ack, relay acks) and re-offers them to a downstream FIFO write port
// (relay requests), through a 2-entry ring buffer. All outputs registered.
// Optional build macro FIFO_RELAY_CNT_EN enables the 16-bit xfer_cnt
// counter of completed downstream transfers; otherwise xfer_cnt is 0.
module fifo_relay #(
    parameter int unsigned dw = 8
) (
    input  logic          clk,
    input  logic          rstn,
    fifo_relay_if.master  bus,
    input  logic          enable,
    output logic [1:0]    level,
    output logic          busy,
    output logic [15:0]   xfer_cnt
);

    typedef enum logic {
        R_IDLE,
        R_ACK
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_DONE
    } wstate_t;

    rstate_t       rstate_q, rstate_d;
    wstate_t       wstate_q, wstate_d;
    logic [dw-1:0] buf_q [2];
    logic          wp_q, wp_d;
    logic          rp_q, rp_d;
    logic [1:0]    level_q, level_d;
    logic          rm_ack_q, rm_ack_d;
    logic          wm_req_q, wm_req_d;
    logic [dw-1:0] wm_data_q, wm_data_d;
    logic          busy_q, busy_d;
    logic          push;
    logic          pop;

    // Next-state decode for both handshake FSMs, pointers, level and busy.
    always_comb begin
        rstate_d  = rstate_q;
        wstate_d  = wstate_q;
        rm_ack_d  = rm_ack_q;
        wm_req_d  = wm_req_q;
        wm_data_d = wm_data_q;
        push      = 1'b0;
        pop       = 1'b0;

        unique case (wstate_q)
            W_IDLE: begin
                if (level_q != 2'd0) begin
                    wm_data_d = buf_q[rp_q];
                    wm_req_d  = 1'b1;
                    wstate_d  = W_REQ;
                end
            end
            W_REQ: begin
                if (bus.wm_ack) begin
                    wm_req_d = 1'b0;
                    pop      = 1'b1;
                    wstate_d = W_DONE;
                end
            end
            W_DONE: begin
                if (!bus.wm_ack) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase

        // A pop on this edge frees its slot: the popped word already sits in
        // wm_data_q, so a full buffer can take a new word on the same edge.
        unique case (rstate_q)
            R_IDLE: begin
                if (bus.rm_req && enable && ((level_q < 2'd2) || pop)) begin
                    push     = 1'b1;
                    rm_ack_d = 1'b1;
                    rstate_d = R_ACK;
                end
            end
            R_ACK: begin
                if (!bus.rm_req) begin
                    rm_ack_d = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase

        wp_d = push ? ~wp_q : wp_q;
        rp_d = pop  ? ~rp_q : rp_q;

        unique case ({push, pop})
            2'b10:   level_d = level_q + 2'd1;
            2'b01:   level_d = level_q - 2'd1;
            default: level_d = level_q;
        endcase

        busy_d = (level_d != 2'd0) || (rstate_d != R_IDLE) || (wstate_d != W_IDLE);
    end

    // State, buffer and registered outputs; reset abandons any transfer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate_q  <= R_IDLE;
            wstate_q  <= W_IDLE;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            level_q   <= '0;
            rm_ack_q  <= 1'b0;
            wm_req_q  <= 1'b0;
            wm_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            wstate_q  <= wstate_d;
            if (push) begin
                buf_q[wp_q] <= bus.rm_data;
            end
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            level_q   <= level_d;
            rm_ack_q  <= rm_ack_d;
            wm_req_q  <= wm_req_d;
            wm_data_q <= wm_data_d;
            busy_q    <= busy_d;
        end
    end

`ifdef FIFO_RELAY_CNT_EN
    logic [15:0] cnt_q;

    // Completed downstream transfers, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = '0;
`endif

    assign bus.rm_ack  = rm_ack_q;
    assign bus.wm_req  = wm_req_q;
    assign bus.wm_data = wm_data_q;
    assign level       = level_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fifo_relay.sv
// tb_fifo_relay: directed and randomized checks of fifo_relay. A monitor
// tracks the words the relay has acknowledged and delivered, and derives
// every expected output from the handshake rules and that occupancy.
// Honours FIFO_RELAY_CNT_EN for the expected xfer_cnt value.
module tb_fifo_relay;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic [1:0]  level;
    logic        busy;
    logic [15:0] xfer_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    fifo_relay_if #(.dw(8)) bus ();

    fifo_relay #(.dw(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .enable   (enable),
        .level    (level),
        .busy     (busy),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / reference model ----------------
    logic       req_s, en_s, ack_s;
    logic [7:0] data_s;

    always @(posedge clk) begin
        req_s  <= bus.rm_req;
        en_s   <= enable;
        ack_s  <= bus.wm_ack;
        data_s <= bus.rm_data;
    end

    logic [7:0]  mq [$];
    int          exp_lvl = 0;
    int          lvl_prev;
    int unsigned pops = 0;
    bit          prev_rm_ack = 0;
    bit          prev_wm_req = 0;
    bit          wdone = 0;
    bit          popped;

    always @(negedge clk) begin
        if (!rstn) begin
            mq.delete();
            exp_lvl     = 0;
            pops        = 0;
            prev_rm_ack = 0;
            prev_wm_req = 0;
            wdone       = 0;
        end else begin
            lvl_prev = exp_lvl;
            popped   = prev_wm_req && !bus.wm_req;
            if (prev_rm_ack)
                chk("rm_ack_hold", bus.rm_ack, req_s);
            else
                chk("rm_accept", bus.rm_ack, req_s && en_s && ((lvl_prev < 2) || popped));
            if (prev_wm_req)
                chk("wm_req_hold", bus.wm_req, !ack_s);
            else if (wdone)
                chk("wm_req_done", bus.wm_req, 1'b0);
            else
                chk("wm_offer", bus.wm_req, lvl_prev > 0);
            if (popped)
                wdone = 1;
            else if (!ack_s)
                wdone = 0;
            if (!prev_rm_ack && bus.rm_ack) begin
                mq.push_back(data_s);
                exp_lvl++;
            end
            if (popped) begin
                if (mq.size() > 0) void'(mq.pop_front());
                exp_lvl--;
                pops++;
            end
            chk("level", level, exp_lvl);
            if (bus.wm_req) begin
                chk("wm_req_has_word", mq.size() > 0, 1'b1);
                if (mq.size() > 0) chk("wm_data", bus.wm_data, mq[0]);
            end
            chk("busy", busy, (exp_lvl != 0) || bus.rm_ack || bus.wm_req || wdone);
`ifdef FIFO_RELAY_CNT_EN
            chk("xfer_cnt", xfer_cnt, pops & 32'h0000_FFFF);
`else
            chk("xfer_cnt", xfer_cnt, 32'd0);
`endif
            prev_rm_ack = bus.rm_ack;
            prev_wm_req = bus.wm_req;
        end
    end

    // ---------------- bounded handshake helpers ----------------
    task automatic wait_rm_ack(input logic v);
        int unsigned n = 0;
        while (bus.rm_ack !== v && n < 200) begin
            tick();
            n++;
        end
        chk("rm_ack_timeout", bus.rm_ack, v);
    endtask

    task automatic wait_wm_req(input logic v);
        int unsigned n = 0;
        while (bus.wm_req !== v && n < 200) begin
            tick();
            n++;
        end
        chk("wm_req_timeout", bus.wm_req, v);
    endtask

    task automatic up_send(input logic [7:0] d);
        bus.rm_data = d;
        bus.rm_req  = 1'b1;
        wait_rm_ack(1'b1);
        bus.rm_req  = 1'b0;
        bus.rm_data = 8'($urandom);
        wait_rm_ack(1'b0);
    endtask

    task automatic dn_take(input logic [7:0] exp, input int unsigned dly);
        wait_wm_req(1'b1);
        chk("dn_word", bus.wm_data, exp);
        repeat (dly) tick();
        bus.wm_ack = 1'b1;
        wait_wm_req(1'b0);
        bus.wm_ack = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [7:0]  sent_q [$];
    bit          up_done;
    localparam int unsigned NR = 300;

    initial begin
        rstn        = 1'b0;
        enable      = 1'b0;
        bus.rm_req  = 1'b0;
        bus.rm_data = '0;
        bus.wm_ack  = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_rm_ack",  bus.rm_ack,  1'b0);
        chk("rst_wm_req",  bus.wm_req,  1'b0);
        chk("rst_wm_data", bus.wm_data, 8'h00);
        chk("rst_level",   level,       2'd0);
        chk("rst_busy",    busy,        1'b0);
        chk("rst_xfer",    xfer_cnt,    16'd0);
        rstn   = 1'b1;
        enable = 1'b1;
        tick();
        chk("idle_level", level, 2'd0);
        chk("idle_busy",  busy,  1'b0);

        // single transfer 0xA5, downstream acks after 3 cycles
        bus.rm_data = 8'hA5;
        bus.rm_req  = 1'b1;
        tick();
        chk("st_rm_ack_1", bus.rm_ack, 1'b1);
        chk("st_wm_req_0", bus.wm_req, 1'b0);
        chk("st_level_1",  level,      2'd1);
        bus.rm_req = 1'b0;
        tick();
        chk("st_wm_req_1", bus.wm_req,  1'b1);
        chk("st_wm_data",  bus.wm_data, 8'hA5);
        repeat (3) tick();
        bus.wm_ack = 1'b1;
        tick();
        chk("st_wm_req_drop", bus.wm_req, 1'b0);
        chk("st_level_0",     level,      2'd0);
        bus.wm_ack = 1'b0;
        tick();
        chk("st_busy_0", busy, 1'b0);
`ifdef FIFO_RELAY_CNT_EN
        chk("st_xfer", xfer_cnt, 16'd1);
`else
        chk("st_xfer", xfer_cnt, 16'd0);
`endif
        chk("st_wm_data_held", bus.wm_data, 8'hA5);

        // full stall, then pop and same-edge accept
        up_send(8'h01);
        up_send(8'h02);
        bus.rm_data = 8'h03;
        bus.rm_req  = 1'b1;
        repeat (5) begin
            tick();
            chk("full_no_ack", bus.rm_ack, 1'b0);
        end
        chk("full_level", level, 2'd2);
        chk("full_head", bus.wm_data, 8'h01);
        bus.wm_ack = 1'b1;
        tick();
        chk("full_pop_req",   bus.wm_req, 1'b0);
        chk("full_push_ack",  bus.rm_ack, 1'b1);
        chk("full_level_2",   level,      2'd2);
        bus.rm_req = 1'b0;
        bus.wm_ack = 1'b0;
        wait_rm_ack(1'b0);
        dn_take(8'h02, 1);
        dn_take(8'h03, 0);

        // simultaneous push and pop at level 1
        up_send(8'h11);
        wait_wm_req(1'b1);
        chk("sim_head", bus.wm_data, 8'h11);
        bus.rm_data = 8'h22;
        bus.rm_req  = 1'b1;
        bus.wm_ack  = 1'b1;
        tick();
        chk("sim_rm_ack", bus.rm_ack, 1'b1);
        chk("sim_wm_req", bus.wm_req, 1'b0);
        chk("sim_level",  level,      2'd1);
        bus.rm_req = 1'b0;
        bus.wm_ack = 1'b0;
        wait_rm_ack(1'b0);
        dn_take(8'h22, 2);

        // enable gating while buffered word drains
        up_send(8'h33);
        enable      = 1'b0;
        bus.rm_data = 8'h44;
        bus.rm_req  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("en_no_ack", bus.rm_ack, 1'b0);
            if (i == 1) bus.wm_ack = 1'b1;
            if (i == 3) bus.wm_ack = 1'b0;
        end
        chk("en_drained_level", level,      2'd0);
        chk("en_drained_req",   bus.wm_req, 1'b0);
        enable = 1'b1;
        tick();
        chk("en_accept", bus.rm_ack, 1'b1);
        bus.rm_req = 1'b0;
        wait_rm_ack(1'b0);
        dn_take(8'h44, 0);

        // randomized traffic against the scoreboard
        up_done = 0;
        fork
            begin
                logic [7:0] d;
                for (int k = 0; k < NR; k++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    d = 8'($urandom);
                    sent_q.push_back(d);
                    up_send(d);
                end
                up_done = 1;
            end
            begin
                while (!up_done) begin
                    enable = ($urandom_range(0, 4) != 0);
                    tick();
                end
                enable = 1'b1;
            end
            begin
                logic [7:0] e;
                for (int k = 0; k < NR; k++) begin
                    wait_wm_req(1'b1);
                    e = (sent_q.size() > 0) ? sent_q.pop_front() : 8'h00;
                    dn_take(e, $urandom_range(0, 3));
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
        join
        tick();
        chk("rand_level_end", level, 2'd0);

        // asynchronous reset mid-R_ACK with one word buffered
        bus.rm_data = 8'h5A;
        bus.rm_req  = 1'b1;
        tick();
        chk("rr_rm_ack", bus.rm_ack, 1'b1);
        chk("rr_level",  level,      2'd1);
        rstn = 1'b0;
        #1;
        chk("rr_async_rm_ack", bus.rm_ack, 1'b0);
        chk("rr_async_wm_req", bus.wm_req, 1'b0);
        chk("rr_async_level",  level,      2'd0);
        chk("rr_async_busy",   busy,       1'b0);
        chk("rr_async_xfer",   xfer_cnt,   16'd0);
        bus.rm_req = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_no_replay", bus.wm_req, 1'b0);
            chk("rr_level_0",   level,      2'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
